// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: run-time coefficient writer for FIR filters.
// Streams signed coefficient words into a shadow bank and swaps the shadow
// bank into the active bank only on a sample boundary (sample_en).
// Optional build macro: FIR_COEFF_SYMMETRIC_EN loads (TAPS+1)/2 words and
// mirrors word k into taps k and TAPS-1-k.
//
// Handshake: a word transfers on any rising edge where cfg_valid && cfg_ready
// are both high; cfg_ready depends only on state (high in LOAD), never on
// cfg_valid, and the sender must hold cfg_data stable while cfg_valid is high.
module fir_coeff_loader #(
    parameter int COEFF_WIDTH = 16,
    parameter int TAPS        = 25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic                          cfg_valid,
    input  logic [COEFF_WIDTH-1:0]        cfg_data,
    output logic                          cfg_ready,
    input  logic                          sample_en,
    output logic [TAPS*COEFF_WIDTH-1:0]   coeff_bus,
    output logic                          active_bank,
    output logic                          busy,
    output logic                          load_done,
    output logic                          err_unexp,
    output logic [1:0]                    fsm_state
);

    localparam int IDX_W = $clog2(TAPS);
`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int NWORDS = (TAPS + 1) / 2;
`else
    localparam int NWORDS = TAPS;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [IDX_W-1:0]              idx;
    logic signed [COEFF_WIDTH-1:0] bank [2][TAPS];
    logic                          wr_en;
    logic                          idx_clr;
    logic                          err_set;
    logic                          err_clr;
    logic                          swap;

`ifdef FIR_COEFF_SYMMETRIC_EN
    logic [IDX_W-1:0]              mirror_idx;
    assign mirror_idx = IDX_W'(TAPS - 1) - idx;
`endif

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        wr_en      = 1'b0;
        idx_clr    = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        swap       = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_next = S_LOAD;
                    idx_clr    = 1'b1;
                    err_clr    = 1'b1;
                end
                // A word offered while idle is dropped and flagged.
                if (cfg_valid) err_set = 1'b1;
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (load_start) begin
                    // Restart wins over a coincident word: nothing is written.
                    idx_clr = 1'b1;
                end else if (cfg_valid) begin
                    wr_en = 1'b1;
                    if (idx == LAST_IDX) state_next = S_PEND;
                end
            end
            S_PEND: begin
                if (cfg_valid) err_set = 1'b1;
                if (sample_en) begin
                    swap       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control registers: state, word index, bank select, done pulse, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            active_bank <= 1'b0;
            load_done   <= 1'b0;
            err_unexp   <= 1'b0;
        end else begin
            state     <= state_next;
            load_done <= swap;
            if (swap)         active_bank <= ~active_bank;
            if (idx_clr)      idx <= '0;
            else if (wr_en)   idx <= idx + IDX_W'(1);
            if (err_set)      err_unexp <= 1'b1;
            else if (err_clr) err_unexp <= 1'b0;
        end
    end

    // Coefficient storage: writes only ever touch the inactive (shadow) bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < TAPS; k++) begin
                    bank[b][k] <= '0;
                end
            end
        end else if (wr_en) begin
            bank[~active_bank][idx] <= cfg_data;
`ifdef FIR_COEFF_SYMMETRIC_EN
            bank[~active_bank][mirror_idx] <= cfg_data;
`endif
        end
    end

    // Active coefficients presented to the filter.
    always_comb begin
        coeff_bus = '0;
        for (int k = 0; k < TAPS; k++) begin
            coeff_bus[k*COEFF_WIDTH +: COEFF_WIDTH] = bank[active_bank][k];
        end
    end

endmodule
